fp32_to_int32_conv: RTL and testbench
=====================================

Name: fp32_to_int32_conv

Overview:
- Fully pipelined converter from IEEE-754 single precision to signed 32-bit two's-complement integer.
- Final stage of the vertex-transform datapath: converts viewport-scaled X/Y/Z/W floats to integer screen coordinates before primitive assembly.
- Sits alongside the FP add/sub and FP divider units; shares their clock/reset.
- Accepts one operand per clock, no handshake.

Parameters:
- LATENCY, 6, clock cycles from input sample to output. Fixed at 6; other values are unsupported.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- areset  input  1  reset; synchronous, active-high (one clock; reset is synchronous and active-high).
- a  input  32  IEEE-754 binary32 operand, sampled every clock.
- q  output  32  signed int32 result, registered.

Behaviour:
- Operand sampled every rising edge, unconditionally. Result for an operand sampled at edge N appears on q after edge N+6 and stays until edge N+7.
- Throughput is 1 per clock. No enable or stall. Holding a constant keeps q constant once the pipeline fills.
- Reset:
  - While areset=1 at an edge, every pipeline register clears to 0, so q=0.
  - After release, q stays 0 until the first post-reset operand emerges 6 cycles later.
  - Reset mid-stream discards all in-flight operands; none appear later.
- Decode: s=a[31], e=a[30:23], f=a[22:0]; significand m={1,f} for normal numbers.
- Rounding: round-to-nearest, ties-to-even, applied to the magnitude before the sign.
- Magnitude computation:
  - Let k = e - 127 (unbiased exponent).
  - k < 0: value < 1. Round using guard/sticky. For e=126, f≠0 the result is 1. For exactly 0.5 (e=126, f=0) the result is 0. For e<126 the result is 0.
  - 0 ≤ k ≤ 23: shift m right by 23-k. Guard = first bit shifted out; sticky = OR of the remaining shifted-out bits. Increment if guard & (sticky | lsb).
  - 24 ≤ k ≤ 30: shift m left by k-23, exact, no rounding.
  - k ≥ 31: overflow unless s=1, k=31, f=0, which is exactly -2^31 → 0x80000000.
- Sign: if s=1, the result is the two's-complement negation of the rounded magnitude.
- Saturation:
  - Positive magnitude ≥ 2^31 after rounding → 0x7FFFFFFF.
  - Negative magnitude > 2^31 → 0x80000000.
  - Rounding carry into bit 31 is also caught by this check.
- Special inputs:
  - ±0 → 0.
  - Denormals (e=0, f≠0) → 0.
  - +Inf → 0x7FFFFFFF; −Inf → 0x80000000.
  - NaN (e=255, f≠0) → 0x7FFFFFFF regardless of sign.
- No status flags. Overflow and NaN are indicated only through the saturated value.
- Stage plan (each stage registered):
  - S1: capture a.
  - S2: decode, classify special/zero/overflow, compute shift amount.
  - S3: barrel shift with guard/sticky collection.
  - S4: round increment.
  - S5: conditional negate.
  - S6: saturate/special override, register to q.
  - Class flags travel alongside the data.

Decomposition:
- Shared package fp32_pkg holds:
  - constants FP32_EXP_W=8, FP32_MAN_W=23, FP32_BIAS=127;
  - INT32_MAX=32'h7FFFFFFF, INT32_MIN=32'h80000000;
  - a class enum {ZERO, NORMAL, INF, NAN}.
- The add/sub and divider units reuse the same package.
- One natural sub-module: fp_shift_sticky, a combinational right/left shifter returning the shifted 32-bit magnitude plus guard and sticky bits. It is instantiated in S3.

Test Plan:
- Reset then stream a=0x43C80000 (400.0), 0x43960000 (300.0), 0x40000000 (2.0), 0x3F800000 (1.0) on consecutive cycles → q=0 for cycles 1-6, then 0x190, 0x12C, 0x2, 0x1 on consecutive cycles.
- Ties and rounding: 0x3F000000 (0.5)→0; 0x3FC00000 (1.5)→2; 0x40200000 (2.5)→2; 0xBFC00000 (−1.5)→0xFFFFFFFE; 0x3F400000 (0.75)→1.
- Boundaries: 0x4EFFFFFF (2147483520.0)→0x7FFFFF80; 0x4F000000 (2^31)→0x7FFFFFFF; 0xCF000000 (−2^31)→0x80000000; 0xCF000001→0x80000000.
- Specials: 0x00000000→0; 0x80000000→0; 0x00000001 (denormal)→0; 0x7F800000→0x7FFFFFFF; 0xFF800000→0x80000000; 0x7FC00000→0x7FFFFFFF.
- Reset mid-stream: feed 0x43C80000 for 3 cycles, assert areset 1 cycle, then feed 0x40000000 → q=0 from the reset edge until exactly 6 cycles after the first post-reset sample, then 0x2. The value 0x190 never appears.
- Random back-to-back: 10k random operands checked against a reference model, output compared 6 cycles later each cycle, with zero mismatches.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the FP datapath units (convert, add/sub, divide).
package fp32_pkg;

   localparam int FP32_EXP_W = 8;
   localparam int FP32_MAN_W = 23;
   localparam int FP32_BIAS  = 127;

   localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] INT32_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ZERO   = 2'd0,
      NORMAL = 2'd1,
      INF    = 2'd2,
      NAN    = 2'd3
   } fp_class_e;

   // Per-operand flags carried down the pipeline beside the data.
   typedef struct packed {
      logic      sgn;
      fp_class_e cls;
      logic      ovf;
   } fp_flags_t;

   // Denormals are flushed, so they classify as ZERO.
   function automatic fp_class_e fp_classify(input logic [7:0] e, input logic [22:0] f);
      if (e == 8'd0)        return ZERO;
      else if (e == 8'hFF)  return (f == 23'd0) ? INF : NAN;
      else                  return NORMAL;
   endfunction

endpackage

// File: rtl/fp_shift_sticky.sv
// Combinational significand shifter: right shift with guard/sticky, or exact left shift.
module fp_shift_sticky
   import fp32_pkg::*;
(
   input  logic [23:0] mag_i,
   input  logic        left_i,
   input  logic [4:0]  amt_i,
   output logic [31:0] res_o,
   output logic        guard_o,
   output logic        sticky_o
);

   logic [63:0] rwide;
   logic [31:0] lres;

   always_comb begin
      // Bits shifted out land in the low word: bit 31 is guard, the rest fold into sticky.
      rwide = {8'd0, mag_i, 32'd0} >> amt_i;
      lres  = {8'd0, mag_i} << amt_i;
      if (left_i) begin
         res_o    = lres;
         guard_o  = 1'b0;
         sticky_o = 1'b0;
      end else begin
         res_o    = rwide[63:32];
         guard_o  = rwide[31];
         sticky_o = |rwide[30:0];
      end
   end

endmodule

// File: rtl/fp32_to_int32_conv.sv
// Pipelined binary32 -> int32 converter, RNE rounding, saturating; 6 clocks sample-to-q.
module fp32_to_int32_conv
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        areset,
   input  logic [31:0] a,
   output logic [31:0] q
);

   // S1 capture
   logic [31:0] a_q;

   // S2 decode
   logic        sgn_d, left_d, ovf_d;
   fp_class_e   cls_d;
   logic [7:0]  e_d;
   logic [4:0]  amt_d;
   fp_flags_t   s2_flg_q;
   logic [23:0] s2_man_q;
   logic        s2_left_q;
   logic [4:0]  s2_amt_q;

   // S3 shift
   logic [31:0] sh_res;
   logic        sh_g, sh_st;
   fp_flags_t   s3_flg_q;
   logic [31:0] s3_mag_q;
   logic        s3_g_q, s3_st_q;

   // S4 round
   logic        inc_d;
   fp_flags_t   s4_flg_q;
   logic [31:0] s4_mag_q;

   // S5 negate
   fp_flags_t   s5_flg_q;
   logic [31:0] s5_val_q;
   logic        s5_big_q;

   // S6 saturate, then output register
   logic [31:0] res_d;
   logic [31:0] s6_res_q;
   logic [31:0] q_q;

   always_comb begin
      e_d   = a_q[30:23];
      sgn_d = a_q[31];
      cls_d = fp_classify(e_d, a_q[22:0]);
      // k >= 31 (e >= 158) cannot be represented except -2^31, which saturation yields anyway.
      ovf_d  = (cls_d == NORMAL) && (e_d >= 8'd158);
      left_d = (e_d >= 8'd151);
      // Right shifts past 25 leave only sticky, so clamp there to keep the shifter narrow.
      if (left_d)             amt_d = 5'(e_d - 8'd150);
      else if (e_d < 8'd125)  amt_d = 5'd25;
      else                    amt_d = 5'(8'd150 - e_d);
   end

   fp_shift_sticky u_shift (
      .mag_i    (s2_man_q),
      .left_i   (s2_left_q),
      .amt_i    (s2_amt_q),
      .res_o    (sh_res),
      .guard_o  (sh_g),
      .sticky_o (sh_st)
   );

   assign inc_d = s3_g_q & (s3_st_q | s3_mag_q[0]);

   always_comb begin
      res_d = s5_val_q;
      if (s5_flg_q.cls == NAN)
         res_d = INT32_MAX;
      else if (s5_flg_q.cls == ZERO)
         res_d = 32'd0;
      else if ((s5_flg_q.cls == INF) || s5_flg_q.ovf || s5_big_q)
         res_d = s5_flg_q.sgn ? INT32_MIN : INT32_MAX;
   end

   always_ff @(posedge clk) begin
      if (areset) begin
         a_q       <= '0;
         s2_flg_q  <= '0;
         s2_man_q  <= '0;
         s2_left_q <= 1'b0;
         s2_amt_q  <= '0;
         s3_flg_q  <= '0;
         s3_mag_q  <= '0;
         s3_g_q    <= 1'b0;
         s3_st_q   <= 1'b0;
         s4_flg_q  <= '0;
         s4_mag_q  <= '0;
         s5_flg_q  <= '0;
         s5_val_q  <= '0;
         s5_big_q  <= 1'b0;
         s6_res_q  <= '0;
         q_q       <= '0;
      end else begin
         a_q       <= a;
         s2_flg_q  <= '{sgn: sgn_d, cls: cls_d, ovf: ovf_d};
         s2_man_q  <= {1'b1, a_q[22:0]};
         s2_left_q <= left_d;
         s2_amt_q  <= amt_d;
         s3_flg_q  <= s2_flg_q;
         s3_mag_q  <= sh_res;
         s3_g_q    <= sh_g;
         s3_st_q   <= sh_st;
         s4_flg_q  <= s3_flg_q;
         s4_mag_q  <= s3_mag_q + {31'd0, inc_d};
         s5_flg_q  <= s4_flg_q;
         s5_val_q  <= s4_flg_q.sgn ? (~s4_mag_q + 32'd1) : s4_mag_q;
         s5_big_q  <= s4_mag_q[31];
         s6_res_q  <= res_d;
         q_q       <= s6_res_q;
      end
   end

   assign q = q_q;

endmodule

// File: tb/tb_fp32_to_int32_conv.sv
// Randomized + directed bench for fp32_to_int32_conv against an arithmetic reference model.
module tb_fp32_to_int32_conv;

   logic        clk;
   logic        areset;
   logic [31:0] a;
   logic [31:0] q;

   int total = 0;
   int bad   = 0;
   int t     = 0;

   logic [31:0] a_hist [0:11999];
   logic        r_hist [0:11999];

   fp32_to_int32_conv dut (
      .clk    (clk),
      .areset (areset),
      .a      (a),
      .q      (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s edge=%0d got=%h exp=%h", tag, t, got, exp);
      end
   endtask

   // Value-level reference: exact m*2^(k-23), remainder compared to one half, then clamp.
   function automatic logic [31:0] ref_cvt(input logic [31:0] v);
      logic        s;
      int          e, k, sh;
      longint      m, ip, rem, half, mag, sv;
      s = v[31];
      e = int'(v[30:23]);
      m = {40'd0, 1'b1, v[22:0]};
      if (e == 255) return (v[22:0] != 0) ? 32'h7FFF_FFFF : (s ? 32'h8000_0000 : 32'h7FFF_FFFF);
      if (e == 0) return 32'd0;
      k = e - 127;
      if (k >= 31) mag = 64'sd1 <<< 40;
      else if (k >= 23) mag = m <<< (k - 23);
      else begin
         sh = 23 - k;
         if (sh > 40) mag = 0;
         else begin
            ip   = m >>> sh;
            rem  = m - (ip <<< sh);
            half = 64'sd1 <<< (sh - 1);
            mag  = ip + (((rem > half) || ((rem == half) && ip[0])) ? 64'sd1 : 64'sd0);
         end
      end
      sv = s ? -mag : mag;
      if (sv > 64'sd2147483647) sv = 64'sd2147483647;
      if (sv < -64'sd2147483648) sv = -64'sd2147483648;
      return sv[31:0];
   endfunction

   // q after edge n is the conversion of the operand sampled at edge n-6,
   // unless reset was high at any edge in that window.
   function automatic logic [31:0] exp_at(input int n);
      if (n < 6) return 32'd0;
      for (int j = n - 6; j <= n; j++)
         if (r_hist[j]) return 32'd0;
      return ref_cvt(a_hist[n - 6]);
   endfunction

   task automatic tick(input string tag);
      @(posedge clk);
      a_hist[t] = a;
      r_hist[t] = areset;
      #1;
      chk(tag, q, exp_at(t));
      t++;
   endtask

   task automatic feed(input string tag, input logic [31:0] v);
      a = v;
      tick(tag);
   endtask

   logic [31:0] dir [0:18];
   logic [31:0] rv;
   logic [31:0] probe;

   initial begin
      dir = '{32'h43C80000, 32'h43960000, 32'h40000000, 32'h3F800000,
              32'h3F000000, 32'h3FC00000, 32'h40200000, 32'hBFC00000, 32'h3F400000,
              32'h4EFFFFFF, 32'h4F000000, 32'hCF000000, 32'hCF000001,
              32'h00000000, 32'h80000000, 32'h00000001, 32'h7F800000, 32'hFF800000,
              32'h7FC00000};
      a      = 32'd0;
      areset = 1'b1;
      for (int i = 0; i < 3; i++) tick("reset");
      areset = 1'b0;

      for (int i = 0; i < 19; i++) feed("directed", dir[i]);
      for (int i = 0; i < 7; i++) feed("drain", 32'h00000000);

      // Spot checks of the reference against hand-derived values.
      probe = ref_cvt(32'h40200000); chk("ref_2p5", probe, 32'h2);
      probe = ref_cvt(32'hBFC00000); chk("ref_m1p5", probe, 32'hFFFFFFFE);
      probe = ref_cvt(32'h4EFFFFFF); chk("ref_max_fp", probe, 32'h7FFFFF80);

      for (int i = 0; i < 3; i++) feed("midrst_pre", 32'h43C80000);
      areset = 1'b1;
      feed("midrst", 32'h43C80000);
      areset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         feed("midrst_post", 32'h40000000);
         if (q == 32'h190) chk("midrst_no400", q, 32'h2);
      end

      for (int i = 0; i < 10000; i++) begin
         rv = $urandom;
         if ($urandom_range(0, 1) == 1) rv[30:23] = 8'($urandom_range(118, 160));
         feed("rand", rv);
      end
      for (int i = 0; i < 8; i++) feed("flush", 32'h3F800000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
